stack_port_arbiter: RTL and testbench
=====================================

# stack_port_arbiter

Two-port front end for a single-ported stack engine. Accepts push/pop requests from two valid/ready requester ports and arbitrates between them, round-robin by default. Issues one transaction at a time to the stack core and routes the core's response back to the requester that issued it. Tracks stack occupancy so that push-when-full, pop-when-empty and illegal commands are answered locally with an error and never reach the core.

## Interface
- DW, 8, data width
- DEPTH, 255, stack capacity in entries
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in0_valid / in1_valid  in  1  request valid
- in0_ready / in1_ready  out  1  request accepted this cycle
- in0_data / in1_data  in  DW  push data; ignored for pop
- in0_cmd / in1_cmd  in  2  00 PUSH, 01 POP, 1x illegal
- out0_valid / out1_valid  out  1  response valid
- out0_ready / out1_ready  in  1  response consumed
- out0_data / out1_data  out  DW  pop data; 0 for push and error responses
- out0_cmd / out1_cmd  out  2  10 PUSH_OKAY, 11 POP_OKAY; value is {1, req_cmd[0]}
- out0_err / out1_err  out  1  response is an error; no stack change
- stk_req_valid  out  1  request to core
- stk_req_ready  in  1  core accepts request
- stk_req_cmd  out  2  PUSH or POP only
- stk_req_data  out  DW  push data
- stk_resp_valid  in  1  core response
- stk_resp_ready  out  1  high only in WAIT
- stk_resp_data  in  DW  pop data
- stk_resp_cmd  in  2  PUSH_OKAY or POP_OKAY
- occupancy  out  $clog2(DEPTH+1)  entries currently held
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbiter picks among valid ports. inN_ready = (state==IDLE) && grant==N. At most one ready is high.
  - On accept, capture port id, cmd and data.
  - Legal request (PUSH with occupancy<DEPTH, or POP with occupancy>0) -> ISSUE.
  - Otherwise -> RESP with err=1.
- ISSUE: stk_req_valid=1 and held stable until stk_req_ready. On handshake, occupancy updates (+1 push, -1 pop), then -> WAIT.
- WAIT: stk_resp_ready=1. On stk_resp_valid, capture data; the data is forced to 0 for push.
  - If stk_resp_cmd != {1, cmd[0]}, set err=1. Occupancy is not rolled back.
  - Then -> RESP.
- RESP: outN_valid=1 only on the captured port, with data/cmd/err held stable. On outN_ready -> IDLE.
- Round-robin: the last_grant register is updated only on accept. With both ports valid, grant goes to !last_grant. With a single port valid, that port wins.
- occupancy saturates by construction: the legality check guarantees the counter never exceeds DEPTH and never wraps below 0.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (port 0 wins first tie), occupancy=0.
  - All valid, ready and err outputs are 0. All data/cmd outputs are 0.
- Reset asserted mid-transaction drops the transaction immediately. No response is issued. The core must be reset concurrently.
- Legal request accepted at cycle t:
  - stk_req_valid at t+1.
  - Earliest core response at t+2 (zero-wait core).
  - outN_valid at t+3.
- Error request accepted at t: outN_valid at t+1.
- Next accept happens no earlier than the cycle after the outN handshake. Throughput is at most one transaction per 4 cycles.
- inN_ready is combinational from state, valids and last_grant. It does not depend on outN_ready.

## Configuration
- STACK_ARB_FIXED_PRIO_EN
  - Defined: port 0 always wins when both ports are valid. last_grant is not implemented.
  - Undefined: round-robin as above.

## Structure
- Shared package stack_pkg holds:
  - CMD_PUSH, CMD_POP, CMD_PUSH_OKAY and CMD_POP_OKAY localparams.
  - The FSM state enum.
  - The OCC_W width function.
- One sub-module, rr_arb2: a two-requester round-robin/fixed-priority picker. Inputs are req[1:0] and last_grant. Outputs are one-hot gnt[1:0]. It honours STACK_ARB_FIXED_PRIO_EN.

## Test plan
- Port 0 PUSH 0xA5, zero-wait core -> stk_req at t+1 with data A5, out0_valid at t+3 with cmd=10, err=0, occupancy=1.
- From reset, both ports valid, port 0 PUSH 0x11 and port 1 PUSH 0x22 -> port 0 served first, then port 1. Then a port 0 POP returns 0x22 with cmd=11. (With FIXED_PRIO: port 0 keeps winning while it stays valid.)
- POP at occupancy=0 -> no stk_req, out valid at t+1 with err=1, data=0, cmd=11, occupancy stays 0.
- Fill to DEPTH, then PUSH -> err=1, occupancy=DEPTH. Then POP -> legal, occupancy=DEPTH-1.
- Hold out1_ready=0 for 5 cycles in RESP, and stall stk_req_ready for 3 cycles -> all outputs stable, no new accept on either port.
- Assert rst while in WAIT -> all outputs 0 the same cycle, occupancy=0. The next request proceeds normally.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the stack port arbiter: command encodings, FSM state
// type and the occupancy counter width helper.
// Combinational only; no latency, no backpressure.
package stack_pkg;

    // Request commands (cmd[1] set marks an illegal request)
    localparam logic [1:0] CMD_PUSH      = 2'b00;
    localparam logic [1:0] CMD_POP       = 2'b01;
    // Response commands: always {1'b1, req_cmd[0]}
    localparam logic [1:0] CMD_PUSH_OKAY = 2'b10;
    localparam logic [1:0] CMD_POP_OKAY  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Bits needed to count 0..depth inclusive
    function automatic int OCC_W(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester picker: round-robin on ties, or port 0 priority when
// STACK_ARB_FIXED_PRIO_EN is defined. Combinational, zero latency.
// No backpressure of its own; the caller decides when a grant is taken.
//
// Ports:
//   req[1:0]    request vector, bit N = port N valid
//   last_grant  port granted on the previous accept (unused in fixed priority)
//   gnt[1:0]    one-hot grant, all-zero when nothing requests
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

`ifdef STACK_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0];
        gnt[1] = req[1] & ~req[0];
    end
`else
    // On a tie the port that did not win last time goes next; a lone
    // requester always wins.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end
`endif

endmodule

// File: rtl/stack_port_arbiter.sv
// Two-port push/pop front end for a single-ported stack core, with local
// error answers for push-when-full, pop-when-empty and illegal commands.
// Latency: legal request -> stk_req next cycle, response 3 cycles after accept
// at best; error response 1 cycle after accept. One transaction in flight;
// inN_ready stays low from accept until the response handshake completes.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   inN_valid/ready/data/cmd  requester ports (cmd 00 PUSH, 01 POP, 1x illegal)
//   outN_valid/ready/data/cmd/err  response ports, routed to the issuing port
//   stk_req_*                 request channel to the stack core
//   stk_resp_*                response channel from the stack core
//   occupancy                 entries currently held by the core
//   busy                      a transaction is in progress
// Build option: STACK_ARB_FIXED_PRIO_EN gives port 0 priority on ties.
module stack_port_arbiter
    import stack_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 255
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       in0_valid,
    output logic                       in0_ready,
    input  logic [DW-1:0]              in0_data,
    input  logic [1:0]                 in0_cmd,
    input  logic                       in1_valid,
    output logic                       in1_ready,
    input  logic [DW-1:0]              in1_data,
    input  logic [1:0]                 in1_cmd,

    output logic                       out0_valid,
    input  logic                       out0_ready,
    output logic [DW-1:0]              out0_data,
    output logic [1:0]                 out0_cmd,
    output logic                       out0_err,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [DW-1:0]              out1_data,
    output logic [1:0]                 out1_cmd,
    output logic                       out1_err,

    output logic                       stk_req_valid,
    input  logic                       stk_req_ready,
    output logic [1:0]                 stk_req_cmd,
    output logic [DW-1:0]              stk_req_data,
    input  logic                       stk_resp_valid,
    output logic                       stk_resp_ready,
    input  logic [DW-1:0]              stk_resp_data,
    input  logic [1:0]                 stk_resp_cmd,

    output logic [OCC_W(DEPTH)-1:0]    occupancy,
    output logic                       busy
);

    localparam int            OW       = OCC_W(DEPTH);
    localparam logic [OW-1:0] OCC_MAX  = OW'(DEPTH);
    localparam logic [OW-1:0] OCC_ONE  = OW'(1);

    state_t          state;
    logic            last_grant;
    logic            cap_port;
    logic [1:0]      cap_cmd;
    logic [DW-1:0]   cap_data;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic [OW-1:0]   occ;

    logic [1:0]      gnt;
    logic [1:0]      sel_cmd;
    logic [DW-1:0]   sel_data;
    logic            legal;
    logic            accept;
    logic            resp_ready;
    logic            resp_active;

    rr_arb2 u_arb (
        .req        ({in1_valid, in0_valid}),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    assign accept   = (state == IDLE) && (gnt != 2'b00);
    assign sel_cmd  = gnt[1] ? in1_cmd  : in0_cmd;
    assign sel_data = gnt[1] ? in1_data : in0_data;

    // The occupancy bounds here are what keep the counter from ever passing
    // DEPTH or wrapping below zero; no separate saturation is needed.
    assign legal = ((sel_cmd == CMD_PUSH) && (occ < OCC_MAX)) ||
                   ((sel_cmd == CMD_POP)  && (occ != '0));

    assign resp_ready = cap_port ? out1_ready : out0_ready;

`ifdef STACK_ARB_FIXED_PRIO_EN
    assign last_grant = 1'b0;
`else
    // Reset to 1 so that port 0 takes the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= gnt[1];
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cap_port <= 1'b0;
            cap_cmd  <= 2'b00;
            cap_data <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            occ      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_port <= gnt[1];
                        cap_cmd  <= sel_cmd;
                        cap_data <= sel_data;
                        rsp_data <= '0;
                        rsp_err  <= ~legal;
                        state    <= legal ? ISSUE : RESP;
                    end
                end
                ISSUE: begin
                    if (stk_req_ready) begin
                        occ   <= (cap_cmd == CMD_PUSH) ? occ + OCC_ONE : occ - OCC_ONE;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (stk_resp_valid) begin
                        rsp_data <= (cap_cmd == CMD_PUSH) ? '0 : stk_resp_data;
                        // A mismatched answer is flagged but the occupancy
                        // change already committed at issue stays in place.
                        rsp_err  <= (stk_resp_cmd != {1'b1, cap_cmd[0]});
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in0_ready      = (state == IDLE) && gnt[0];
    assign in1_ready      = (state == IDLE) && gnt[1];

    assign stk_req_valid  = (state == ISSUE);
    assign stk_req_cmd    = stk_req_valid ? cap_cmd  : 2'b00;
    assign stk_req_data   = stk_req_valid ? cap_data : '0;
    assign stk_resp_ready = (state == WAIT);

    assign resp_active    = (state == RESP);
    assign out0_valid     = resp_active && !cap_port;
    assign out1_valid     = resp_active &&  cap_port;
    assign out0_data      = out0_valid ? rsp_data : '0;
    assign out1_data      = out1_valid ? rsp_data : '0;
    assign out0_cmd       = out0_valid ? {1'b1, cap_cmd[0]} : 2'b00;
    assign out1_cmd       = out1_valid ? {1'b1, cap_cmd[0]} : 2'b00;
    assign out0_err       = out0_valid && rsp_err;
    assign out1_err       = out1_valid && rsp_err;

    assign occupancy      = occ;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_stack_port_arbiter.sv
// Directed bench for stack_port_arbiter with a zero-wait stack core model.
// Inputs change on the falling edge; outputs are checked a step later.
// The core model answers one cycle after each accepted request.
module tb_stack_port_arbiter;

    localparam int DW    = 8;
    localparam int DEPTH = 255;

    logic          clk;
    logic          rst;
    logic          in0_valid, in0_ready, in1_valid, in1_ready;
    logic [DW-1:0] in0_data, in1_data;
    logic [1:0]    in0_cmd, in1_cmd;
    logic          out0_valid, out0_ready, out1_valid, out1_ready;
    logic [DW-1:0] out0_data, out1_data;
    logic [1:0]    out0_cmd, out1_cmd;
    logic          out0_err, out1_err;
    logic          stk_req_valid, stk_req_ready;
    logic [1:0]    stk_req_cmd;
    logic [DW-1:0] stk_req_data;
    logic          stk_resp_valid, stk_resp_ready;
    logic [DW-1:0] stk_resp_data;
    logic [1:0]    stk_resp_cmd;
    logic [7:0]    occupancy;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    // Core model controls
    logic          core_bad;
    logic [7:0]    mem [0:255];
    int            sp;

    stack_port_arbiter #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in0_valid      (in0_valid),
        .in0_ready      (in0_ready),
        .in0_data       (in0_data),
        .in0_cmd        (in0_cmd),
        .in1_valid      (in1_valid),
        .in1_ready      (in1_ready),
        .in1_data       (in1_data),
        .in1_cmd        (in1_cmd),
        .out0_valid     (out0_valid),
        .out0_ready     (out0_ready),
        .out0_data      (out0_data),
        .out0_cmd       (out0_cmd),
        .out0_err       (out0_err),
        .out1_valid     (out1_valid),
        .out1_ready     (out1_ready),
        .out1_data      (out1_data),
        .out1_cmd       (out1_cmd),
        .out1_err       (out1_err),
        .stk_req_valid  (stk_req_valid),
        .stk_req_ready  (stk_req_ready),
        .stk_req_cmd    (stk_req_cmd),
        .stk_req_data   (stk_req_data),
        .stk_resp_valid (stk_resp_valid),
        .stk_resp_ready (stk_resp_ready),
        .stk_resp_data  (stk_resp_data),
        .stk_resp_cmd   (stk_resp_cmd),
        .occupancy      (occupancy),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait stack core; push answers carry junk data so that the
    // arbiter's zero-forcing is visible.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stk_resp_valid <= 1'b0;
            stk_resp_data  <= '0;
            stk_resp_cmd   <= 2'b00;
            sp             <= 0;
        end else begin
            if (stk_resp_valid && stk_resp_ready) stk_resp_valid <= 1'b0;
            if (stk_req_valid && stk_req_ready) begin
                stk_resp_valid <= 1'b1;
                if (stk_req_cmd == 2'b00) begin
                    mem[sp[7:0]]  <= stk_req_data;
                    sp            <= sp + 1;
                    stk_resp_data <= 8'hEE;
                    stk_resp_cmd  <= core_bad ? 2'b11 : 2'b10;
                end else begin
                    sp            <= sp - 1;
                    stk_resp_data <= mem[sp[7:0] - 8'd1];
                    stk_resp_cmd  <= core_bad ? 2'b10 : 2'b11;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic ov(input int p);
        return (p != 0) ? out1_valid : out0_valid;
    endfunction

    // Request on `port` is already presented and expected to be granted now.
    task automatic serve(input int port, input logic [1:0] ecmd, input logic [7:0] edata,
                         input logic eerr, input int elat, input string tag);
        int n;
        check({tag, "_rdy"},   (port != 0) ? in1_ready : in0_ready, 1);
        check({tag, "_nrdy"},  (port != 0) ? in0_ready : in1_ready, 0);
        step();
        if (port != 0) in1_valid = 1'b0; else in0_valid = 1'b0;
        #1;
        check({tag, "_req"}, stk_req_valid, (elat == 3) ? 1 : 0);
        n = 1;
        while (!ov(port) && n < 20) begin
            step();
            n++;
        end
        #1;
        check({tag, "_lat"},  n, elat);
        check({tag, "_data"}, (port != 0) ? out1_data : out0_data, edata);
        check({tag, "_cmd"},  (port != 0) ? out1_cmd  : out0_cmd,  ecmd);
        check({tag, "_err"},  (port != 0) ? out1_err  : out0_err,  eerr);
        check({tag, "_oth"},  ov(1 - port), 0);
        if (port != 0) out1_ready = 1'b1; else out0_ready = 1'b1;
        step();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
    endtask

    task automatic txn(input int port, input logic [1:0] cmd, input logic [7:0] data,
                       input logic [1:0] ecmd, input logic [7:0] edata,
                       input logic eerr, input int elat, input string tag);
        if (port != 0) begin
            in1_valid = 1'b1; in1_cmd = cmd; in1_data = data;
        end else begin
            in0_valid = 1'b1; in0_cmd = cmd; in0_data = data;
        end
        #1;
        serve(port, ecmd, edata, eerr, elat, tag);
    endtask

    initial begin
        rst = 1'b1;
        in0_valid = 0; in0_data = 0; in0_cmd = 0;
        in1_valid = 0; in1_data = 0; in1_cmd = 0;
        out0_ready = 0; out1_ready = 0;
        stk_req_ready = 1'b1;
        core_bad = 1'b0;

        // Reset state
        step();
        check("rst_busy", busy, 0);
        check("rst_occ", occupancy, 0);
        check("rst_out0", {out0_valid, out0_err, out0_cmd, out0_data}, 0);
        check("rst_out1", {out1_valid, out1_err, out1_cmd, out1_data}, 0);
        check("rst_stk", {stk_req_valid, stk_resp_ready, stk_req_cmd, stk_req_data}, 0);
        rst = 1'b0;
        step();

        // Single push, cycle by cycle
        in0_valid = 1; in0_cmd = 2'b00; in0_data = 8'hA5;
        #1;
        check("p1_rdy0", in0_ready, 1);
        check("p1_rdy1", in1_ready, 0);
        step();
        in0_valid = 0;
        #1;
        check("p1_reqv", stk_req_valid, 1);
        check("p1_reqd", stk_req_data, 8'hA5);
        check("p1_reqc", stk_req_cmd, 2'b00);
        step();
        check("p1_wait", stk_resp_ready, 1);
        check("p1_occ", occupancy, 1);
        check("p1_out_early", out0_valid, 0);
        step();
        check("p1_outv", out0_valid, 1);
        check("p1_cmd", out0_cmd, 2'b10);
        check("p1_err", out0_err, 0);
        check("p1_data", out0_data, 0);
        out0_ready = 1;
        step();
        out0_ready = 0;
        check("p1_idle", busy, 0);

        // Fresh reset, then tie between both ports
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("tie_occ0", occupancy, 0);
        in0_valid = 1; in0_cmd = 2'b00; in0_data = 8'h11;
        in1_valid = 1; in1_cmd = 2'b00; in1_data = 8'h22;
        #1;
        serve(0, 2'b10, 8'h00, 0, 3, "tie_p0");
        in0_valid = 1; in0_cmd = 2'b01;
        #1;
`ifdef STACK_ARB_FIXED_PRIO_EN
        serve(0, 2'b11, 8'h11, 0, 3, "fp_pop");
        serve(1, 2'b10, 8'h00, 0, 3, "fp_push");
        check("tie_occ", occupancy, 1);
        txn(0, 2'b01, 8'h00, 2'b11, 8'h22, 0, 3, "tie_last_pop");
`else
        serve(1, 2'b10, 8'h00, 0, 3, "rr_p1");
        serve(0, 2'b11, 8'h22, 0, 3, "rr_pop");
        check("tie_occ", occupancy, 1);
        txn(0, 2'b01, 8'h00, 2'b11, 8'h11, 0, 3, "tie_last_pop");
`endif
        check("tie_occ_end", occupancy, 0);

        // Local errors
        txn(0, 2'b01, 8'h00, 2'b11, 8'h00, 1, 1, "pop_empty");
        check("pop_empty_occ", occupancy, 0);
        txn(1, 2'b10, 8'h99, 2'b10, 8'h00, 1, 1, "ill10");
        txn(1, 2'b11, 8'h99, 2'b11, 8'h00, 1, 1, "ill11");
        check("ill_occ", occupancy, 0);

        // Fill to capacity
        for (int i = 0; i < DEPTH; i++) begin
            txn(i % 2, 2'b00, 8'(i), 2'b10, 8'h00, 0, 3, "fill");
        end
        check("full_occ", occupancy, 255);
        txn(0, 2'b00, 8'hFF, 2'b10, 8'h00, 1, 1, "push_full");
        check("push_full_occ", occupancy, 255);
        txn(1, 2'b01, 8'h00, 2'b11, 8'hFE, 0, 3, "pop_full");
        check("pop_full_occ", occupancy, 254);

        // Core stall and response backpressure
        stk_req_ready = 1'b0;
        in1_valid = 1; in1_cmd = 2'b00; in1_data = 8'h5A;
        #1;
        check("st_rdy1", in1_ready, 1);
        step();
        in1_valid = 0;
        in0_valid = 1; in0_cmd = 2'b01; in0_data = 8'h00;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("st_reqv", stk_req_valid, 1);
            check("st_reqd", stk_req_data, 8'h5A);
            check("st_reqc", stk_req_cmd, 2'b00);
            check("st_nrdy0", in0_ready, 0);
            check("st_occ", occupancy, 254);
            step();
        end
        stk_req_ready = 1'b1;
        step();
        check("st_wait", stk_resp_ready, 1);
        check("st_occ_up", occupancy, 255);
        step();
        for (int k = 0; k < 5; k++) begin
            check("bp_v", out1_valid, 1);
            check("bp_dce", {out1_data, out1_cmd, out1_err}, {8'h00, 2'b10, 1'b0});
            check("bp_nrdy", {in0_ready, in1_ready, out0_valid, stk_req_valid}, 0);
            step();
        end
        out1_ready = 1;
        step();
        out1_ready = 0;
        #1;
        serve(0, 2'b11, 8'h5A, 0, 3, "after_stall");
        check("after_stall_occ", occupancy, 254);

        // Reset while waiting on the core
        in0_valid = 1; in0_cmd = 2'b00; in0_data = 8'h77;
        #1;
        step();
        in0_valid = 0;
        step();
        check("rw_wait", stk_resp_ready, 1);
        check("rw_occ", occupancy, 255);
        rst = 1'b1;
        #1;
        check("rw_stk", {stk_req_valid, stk_resp_ready, stk_req_cmd, stk_req_data}, 0);
        check("rw_out0", {out0_valid, out0_err, out0_cmd, out0_data}, 0);
        check("rw_out1", {out1_valid, out1_err, out1_cmd, out1_data}, 0);
        check("rw_occ0", occupancy, 0);
        check("rw_busy", busy, 0);
        step();
        rst = 1'b0;
        step();
        txn(0, 2'b01, 8'h00, 2'b11, 8'h00, 1, 1, "post_rst_pop");
        txn(0, 2'b00, 8'h3C, 2'b10, 8'h00, 0, 3, "post_rst_push");
        check("post_rst_occ", occupancy, 1);

        // Core answers with the wrong command: error, occupancy kept
        core_bad = 1'b1;
        txn(1, 2'b00, 8'h44, 2'b10, 8'h00, 1, 3, "bad_cmd");
        core_bad = 1'b0;
        check("bad_cmd_occ", occupancy, 2);
        txn(1, 2'b01, 8'h00, 2'b11, 8'h44, 0, 3, "bad_pop");
        check("bad_pop_occ", occupancy, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
